// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions used by both the PRBS generator and the checker.
package lfsr_pkg;

    localparam int         LFSR_WIDTH = 8;
    localparam logic [7:0] LFSR_TAPS  = 8'hB8;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_e;

endpackage

// File: rtl/lfsr_seq_checker_if.sv
// Bus between a PRBS word source and the sequence checker.
interface lfsr_seq_checker_if #(
    parameter int WIDTH = lfsr_pkg::LFSR_WIDTH,
    parameter int CNT_W = 16
);

    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             clear_cnt;
    logic             locked;
    logic             error;
    logic [CNT_W-1:0] err_count;
    logic             err_sticky;

    modport master (
        output data_in, data_valid, clear_cnt,
        input  locked, error, err_count, err_sticky
    );

    modport slave (
        input  data_in, data_valid, clear_cnt,
        output locked, error, err_count, err_sticky
    );

endinterface

// File: rtl/lfsr_next.sv
// Combinational one-step advance of a Fibonacci LFSR (shift left, parity of tapped bits in at LSB).
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    assign nxt = {cur[WIDTH-2:0], ^(cur & TAPS)};

endmodule

// File: rtl/lfsr_seq_checker.sv
// PRBS receive checker: locks onto an incoming LFSR stream, then flags and counts bad words.
module lfsr_seq_checker
    import lfsr_pkg::*;
#(
    parameter int               WIDTH      = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS       = LFSR_TAPS,
    parameter int               LOCK_CNT   = 4,
    parameter int               UNLOCK_CNT = 4,
    parameter int               CNT_W      = 16
) (
    input logic               clk,
    input logic               reset,
    lfsr_seq_checker_if.slave bus
);

    localparam logic [3:0] LOCK_TH   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_TH = 4'(UNLOCK_CNT);

    chk_state_e       state_q, state_d;
    logic [WIDTH-1:0] pred_q, pred_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [3:0]       miss_cnt_q, miss_cnt_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             err_sticky_q, err_sticky_d;

    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] next_of_word;
    logic [WIDTH-1:0] next_of_pred;

    assign word = bus.data_in;

    lfsr_next #(.WIDTH(WIDTH), .TAPS(TAPS)) u_next_word (
        .cur (word),
        .nxt (next_of_word)
    );

    lfsr_next #(.WIDTH(WIDTH), .TAPS(TAPS)) u_next_pred (
        .cur (pred_q),
        .nxt (next_of_pred)
    );

    always_comb begin
        state_d      = state_q;
        pred_d       = pred_q;
        match_cnt_d  = match_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        error_d      = 1'b0;
        err_count_d  = err_count_q;
        err_sticky_d = err_sticky_q;

        if (bus.data_valid) begin
            case (state_q)
                // Reseed from every received word; an all-zero word can never count as a match.
                SEARCH: begin
                    pred_d = next_of_word;
                    if ((word == pred_q) && (word != '0)) begin
                        if (match_cnt_q + 4'd1 >= LOCK_TH) begin
                            match_cnt_d = LOCK_TH;
                            miss_cnt_d  = '0;
                            state_d     = LOCKED;
                        end else begin
                            match_cnt_d = match_cnt_q + 4'd1;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                // Prediction free-runs so one corrupted word costs exactly one error.
                LOCKED: begin
                    pred_d = next_of_pred;
                    if (word == pred_q) begin
                        miss_cnt_d = '0;
                    end else begin
                        error_d      = 1'b1;
                        err_sticky_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + CNT_W'(1);
                        end
                        if (miss_cnt_q + 4'd1 >= UNLOCK_TH) begin
                            state_d     = SEARCH;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                            pred_d      = next_of_word;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 4'd1;
                        end
                    end
                end
            endcase
        end

        if (bus.clear_cnt) begin
            err_count_d  = '0;
            err_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SEARCH;
            pred_q       <= '0;
            match_cnt_q  <= '0;
            miss_cnt_q   <= '0;
            error_q      <= 1'b0;
            err_count_q  <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pred_q       <= pred_d;
            match_cnt_q  <= match_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            error_q      <= error_d;
            err_count_q  <= err_count_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign bus.locked     = (state_q == LOCKED);
    assign bus.error      = error_q;
    assign bus.err_count  = err_count_q;
    assign bus.err_sticky = err_sticky_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Scoreboard bench for lfsr_seq_checker: a behavioural model queues expected outputs per driven cycle.
module tb_lfsr_seq_checker;
    import lfsr_pkg::*;

    localparam int CNT_W  = 4;
    localparam int LOCK   = 4;
    localparam int UNLOCK = 4;

    typedef struct packed {
        logic             locked;
        logic             error;
        logic [CNT_W-1:0] cnt;
        logic             sticky;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    lfsr_seq_checker_if #(.WIDTH(LFSR_WIDTH), .CNT_W(CNT_W)) bus ();

    lfsr_seq_checker #(
        .WIDTH      (LFSR_WIDTH),
        .TAPS       (LFSR_TAPS),
        .LOCK_CNT   (LOCK),
        .UNLOCK_CNT (UNLOCK),
        .CNT_W      (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t             exp_q[$];
    int               errors = 0;
    int               checks = 0;
    string            phase  = "init";

    logic             m_locked = 1'b0;
    logic [7:0]       m_pred   = 8'h00;
    int               m_match  = 0;
    int               m_miss   = 0;
    logic [CNT_W-1:0] m_cnt    = '0;
    logic             m_sticky = 1'b0;
    logic [7:0]       cur;
    logic [7:0]       bad;

    function automatic logic [7:0] tbNext(input logic [7:0] x);
        return {x[6:0], ^(x & 8'hB8)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference behaviour of the checker for one clock edge.
    task automatic modelStep(input logic rst, input logic valid, input logic [7:0] w, input logic clr,
                             output exp_t e);
        logic err;
        err = 1'b0;
        if (rst) begin
            m_locked = 1'b0; m_pred = 8'h00; m_match = 0; m_miss = 0; m_cnt = '0; m_sticky = 1'b0;
        end else begin
            if (valid) begin
                if (!m_locked) begin
                    if (w == m_pred && w != 8'h00) begin
                        m_match++;
                        if (m_match >= LOCK) begin
                            m_locked = 1'b1;
                            m_miss   = 0;
                        end
                    end else begin
                        m_match = 0;
                    end
                    m_pred = tbNext(w);
                end else if (w == m_pred) begin
                    m_miss = 0;
                    m_pred = tbNext(m_pred);
                end else begin
                    err      = 1'b1;
                    m_sticky = 1'b1;
                    if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
                    m_miss++;
                    m_pred = tbNext(m_pred);
                    if (m_miss >= UNLOCK) begin
                        m_locked = 1'b0;
                        m_match  = 0;
                        m_miss   = 0;
                        m_pred   = tbNext(w);
                    end
                end
            end
            if (clr) begin
                m_cnt    = '0;
                m_sticky = 1'b0;
            end
        end
        e.locked = m_locked;
        e.error  = err;
        e.cnt    = m_cnt;
        e.sticky = m_sticky;
    endtask

    task automatic applyStimulus(input logic rst, input logic valid, input logic [7:0] w, input logic clr);
        exp_t e;
        exp_t got;
        reset          = rst;
        bus.data_valid = valid;
        bus.data_in    = w;
        bus.clear_cnt  = clr;
        modelStep(rst, valid, w, clr, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        checkOutput({phase, ".locked"}, 32'(bus.locked), 32'(got.locked));
        checkOutput({phase, ".error"}, 32'(bus.error), 32'(got.error));
        checkOutput({phase, ".err_count"}, 32'(bus.err_count), 32'(got.cnt));
        checkOutput({phase, ".err_sticky"}, 32'(bus.err_sticky), 32'(got.sticky));
    endtask

    task automatic sendWord(input logic [7:0] w);
        applyStimulus(1'b0, 1'b1, w, 1'b0);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic sendLockSeq();
        sendWord(8'h01); sendWord(8'h02); sendWord(8'h04); sendWord(8'h08); sendWord(8'h11);
    endtask

    initial begin
        bus.data_in    = 8'h00;
        bus.data_valid = 1'b0;
        bus.clear_cnt  = 1'b0;

        phase = "reset";
        doReset();
        checkOutput("reset_locked", 32'(bus.locked), 32'd0);
        checkOutput("reset_count", 32'(bus.err_count), 32'd0);

        phase = "lock";
        sendWord(8'h01); sendWord(8'h02); sendWord(8'h04); sendWord(8'h08);
        checkOutput("lock_not_yet", 32'(bus.locked), 32'd0);
        sendWord(8'h11);
        checkOutput("lock_after_11", 32'(bus.locked), 32'd1);
        sendWord(8'h23); sendWord(8'h47); sendWord(8'h8E);
        checkOutput("lock_count", 32'(bus.err_count), 32'd0);

        phase = "single_err";
        doReset();
        sendLockSeq();
        sendWord(8'h00);
        checkOutput("single_pulse", 32'(bus.error), 32'd1);
        sendWord(8'h47);
        checkOutput("single_pulse_end", 32'(bus.error), 32'd0);
        sendWord(8'h8E);
        checkOutput("single_count", 32'(bus.err_count), 32'd1);
        checkOutput("single_sticky", 32'(bus.err_sticky), 32'd1);
        checkOutput("single_locked", 32'(bus.locked), 32'd1);

        phase = "unlock";
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("clear_idle", 32'(bus.err_count), 32'd0);
        sendWord(8'hFF); sendWord(8'hFF); sendWord(8'hFF);
        checkOutput("unlock_held", 32'(bus.locked), 32'd1);
        sendWord(8'hFF);
        checkOutput("unlock_fall", 32'(bus.locked), 32'd0);
        checkOutput("unlock_count", 32'(bus.err_count), 32'd4);
        sendLockSeq();
        checkOutput("relock", 32'(bus.locked), 32'd1);

        phase = "zeros";
        doReset();
        for (int i = 0; i < 10; i++) sendWord(8'h00);
        checkOutput("zeros_locked", 32'(bus.locked), 32'd0);
        checkOutput("zeros_count", 32'(bus.err_count), 32'd0);

        phase = "gaps";
        doReset();
        cur = 8'h01;
        for (int i = 0; i < 5; i++) begin
            sendWord(cur);
            applyStimulus(1'b0, 1'b0, 8'hA5, 1'b0);
            cur = tbNext(cur);
        end
        checkOutput("gaps_locked", 32'(bus.locked), 32'd1);

        phase = "saturate";
        for (int i = 0; i < 20; i++) begin
            bad = cur ^ (8'h01 << $urandom_range(7, 0));
            sendWord(bad);
            cur = tbNext(cur);
            sendWord(cur);
            cur = tbNext(cur);
        end
        checkOutput("sat_count", 32'(bus.err_count), 32'd15);
        checkOutput("sat_sticky", 32'(bus.err_sticky), 32'd1);
        checkOutput("sat_locked", 32'(bus.locked), 32'd1);

        phase = "clear_vs_err";
        applyStimulus(1'b0, 1'b1, cur ^ 8'h80, 1'b1);
        cur = tbNext(cur);
        checkOutput("clr_err_pulse", 32'(bus.error), 32'd1);
        checkOutput("clr_err_count", 32'(bus.err_count), 32'd0);
        checkOutput("clr_err_sticky", 32'(bus.err_sticky), 32'd0);
        sendWord(cur ^ 8'h01);
        cur = tbNext(cur);
        sendWord(cur);

        phase = "reset_locked";
        applyStimulus(1'b1, 1'b1, cur, 1'b0);
        checkOutput("rst_locked", 32'(bus.locked), 32'd0);
        checkOutput("rst_error", 32'(bus.error), 32'd0);
        checkOutput("rst_count", 32'(bus.err_count), 32'd0);
        checkOutput("rst_sticky", 32'(bus.err_sticky), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_seq_checker.md
Name: lfsr_seq_checker

Overview:
- Downstream consumer of the 8-bit LFSR pattern generator; samples each generated word and checks it against its own locally predicted sequence.
- Locks onto the incoming stream, then flags and counts mismatching words.
- Used as the receive/check half of the PRBS self-test path: generator → channel under test → checker.

Parameters:
- WIDTH, 8, word width; matches the generator's data bus.
- TAPS, 8'hB8, feedback mask: next(x) = {x[WIDTH-2:0], ^(x & TAPS)}; bits 7,5,4,3 by default.
- LOCK_CNT, 4, consecutive correct predictions needed to enter LOCKED (1..15).
- UNLOCK_CNT, 4, consecutive mismatches in LOCKED that force return to SEARCH (1..15).
- CNT_W, 16, error-counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  WIDTH  word from the LFSR generator.
- data_valid  in  1  data_in is a new sequence word this cycle.
- clear_cnt  in  1  synchronous clear of err_count and sticky flag; does not affect lock state.
- locked  out  1  checker is in LOCKED.
- error  out  1  one-cycle pulse: the word sampled in the previous cycle mismatched while LOCKED.
- err_count  out  CNT_W  saturating count of mismatches while LOCKED.
- err_sticky  out  1  set on any error; cleared only by reset or clear_cnt.

Behaviour:
Reset:
- Applies when reset=1 at a clk edge.
- Outputs: locked=0, error=0, err_count=0, err_sticky=0.
- Internal: state=SEARCH, pred=0, match/miss counters=0.
- Reset overrides every other input. A reset mid-stream discards lock; the checker relocks normally afterwards.

Input sampling:
- Only cycles with data_valid=1 are evaluated.
- Cycles with data_valid=0 hold all state; error is driven 0.

SEARCH state:
- Each valid word w:
  - If w == pred and w != 0: match_cnt++. If match_cnt reaches LOCK_CNT, go to LOCKED.
  - Otherwise: match_cnt=0.
  - In both cases pred ← next(w), i.e. reseed from the received word.
- All-zero word: always treated as a mismatch (LFSR lockup value); pred stays 0 so the next word cannot match.

LOCKED state:
- pred free-runs: pred ← next(pred) on every valid word, regardless of w. A single bad word therefore yields exactly one error, not two.
- w == pred: miss_cnt=0.
- w != pred:
  - error=1 on the next cycle; err_count++ (saturating at 2^CNT_W-1); err_sticky=1; miss_cnt++.
  - If miss_cnt reaches UNLOCK_CNT: go to SEARCH, locked=0, match_cnt=0, pred ← next(w).

Latency and timing:
- locked, error, err_count and err_sticky are registered.
- All four reflect the word sampled at edge N from edge N+1.

Simultaneous events:
- clear_cnt together with an error: the clear wins; err_count=0 and err_sticky=0. The error pulse is still produced.
- clear_cnt in SEARCH only clears the counters.

Width and arithmetic:
- Comparison is full WIDTH.
- Counters never wrap: err_count saturates; match_cnt and miss_cnt are 4-bit and clamp at their thresholds.

Decomposition:
- Shared package lfsr_pkg:
  - LFSR_WIDTH=8 and LFSR_TAPS=8'hB8 (the generator uses the same pair).
  - State encoding: SEARCH=1'b0, LOCKED=1'b1.
- Sub-module lfsr_next: purely combinational next-value function, parameterised by WIDTH/TAPS. Instantiated by the checker and reusable by the generator.

Test Plan:
1. Reset, then data_valid=1 every cycle feeding 01,02,04,08,11,23,47,8E → locked rises one cycle after 11 is sampled; error never asserts; err_count=0.
2. After lock, substitute 00 for 23, then continue 47,8E → exactly one error pulse (cycle after 00); err_count=1; err_sticky=1; locked stays 1.
3. After lock, feed 4 consecutive wrong words (FF,FF,FF,FF) → 4 error pulses; err_count=4; locked falls the cycle after the 4th; restarting at 01,02,04,08,11 relocks.
4. Stream of all-zero words for 10 cycles from reset → locked stays 0; err_count=0.
5. Toggle data_valid 1/0 during sequence 01..11 → lock achieved after the same 5 valid words; idle cycles change nothing.
6. With CNT_W=4, inject 20 single-word errors while locked → err_count saturates at 15. Then assert clear_cnt → err_count=0, err_sticky=0. Then assert reset while locked → all outputs 0 on the next edge.
